// File: rtl/uart_cmd_parser.sv
// Byte-stream command decoder: 7E/CMD/ARG/CHK frames from the UART receiver drive player controls.
// Optional inter-byte gap timeout is built when CMD_PARSER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module uart_cmd_parser #(
  parameter int unsigned VOL_MAX        = 31,
  parameter int unsigned VOL_DEFAULT    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_over,
  input  logic [7:0] rx_data,
  output logic       play,
  output logic [4:0] volume,
  output logic [7:0] track,
  output logic       next_pulse,
  output logic       prev_pulse,
  output logic       track_load,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam logic [7:0] HDR_BYTE  = 8'h7E;
  localparam logic [7:0] OP_PLAY   = 8'h01;
  localparam logic [7:0] OP_PAUSE  = 8'h02;
  localparam logic [7:0] OP_NEXT   = 8'h03;
  localparam logic [7:0] OP_PREV   = 8'h04;
  localparam logic [7:0] OP_VOLUME = 8'h05;
  localparam logic [7:0] OP_TRACK  = 8'h06;
  localparam logic [7:0] VOL_MAX_8 = 8'(VOL_MAX);
  localparam logic [4:0] VOL_MAX_5 = 5'(VOL_MAX);
  localparam logic [4:0] VOL_DEF_5 = 5'(VOL_DEFAULT);

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_CMD = 2'd1,
    S_ARG = 2'd2,
    S_CHK = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic chk_ok(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
    return (chk == (cmd ^ arg));
  endfunction

  logic       sync1_r, sync2_r, sync3_r;
  logic       byte_stb_r;
  logic [7:0] byte_q_r;
  state_t     state_r;
  logic [7:0] cmd_r, arg_r;
  logic       play_r;
  logic [4:0] volume_r;
  logic [7:0] track_r;
  logic       next_pulse_r, prev_pulse_r, track_load_r, frame_err_r;
  logic [7:0] err_count_r;
  logic       timeout_s;

  // Synchronize rx_over, detect its rising edge and capture the byte alongside the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      sync3_r    <= 1'b0;
      byte_stb_r <= 1'b0;
      byte_q_r   <= 8'h00;
    end else begin
      sync1_r    <= rx_over;
      sync2_r    <= sync1_r;
      sync3_r    <= sync2_r;
      byte_stb_r <= sync2_r & ~sync3_r;
      if (sync2_r & ~sync3_r) begin
        byte_q_r <= rx_data;
      end
    end
  end

`ifdef CMD_PARSER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] gap_cnt_r;

  // Inter-byte gap counter; idle in S_HDR and restarted by every byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_r <= '0;
    end else if ((state_r == S_HDR) || byte_stb_r) begin
      gap_cnt_r <= '0;
    end else if (gap_cnt_r != CNT_LAST) begin
      gap_cnt_r <= gap_cnt_r + 1'b1;
    end
  end

  // A strobe in the same cycle takes priority over the timeout.
  assign timeout_s = (state_r != S_HDR) && (gap_cnt_r == CNT_LAST) && !byte_stb_r;
`else
  assign timeout_s = 1'b0;
`endif

  // Frame FSM with registered control outputs and single-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_HDR;
      cmd_r        <= 8'h00;
      arg_r        <= 8'h00;
      play_r       <= 1'b0;
      volume_r     <= VOL_DEF_5;
      track_r      <= 8'h00;
      next_pulse_r <= 1'b0;
      prev_pulse_r <= 1'b0;
      track_load_r <= 1'b0;
      frame_err_r  <= 1'b0;
      err_count_r  <= 8'h00;
    end else begin
      next_pulse_r <= 1'b0;
      prev_pulse_r <= 1'b0;
      track_load_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (byte_stb_r) begin
        case (state_r)
          S_HDR: begin
            if (byte_q_r == HDR_BYTE) begin
              state_r <= S_CMD;
            end else begin
              state_r <= S_HDR;
            end
          end
          S_CMD: begin
            cmd_r   <= byte_q_r;
            state_r <= S_ARG;
          end
          S_ARG: begin
            arg_r   <= byte_q_r;
            state_r <= S_CHK;
          end
          S_CHK: begin
            state_r <= S_HDR;
            if (!chk_ok(cmd_r, arg_r, byte_q_r)) begin
              frame_err_r <= 1'b1;
              err_count_r <= sat_inc(err_count_r);
            end else begin
              case (cmd_r)
                OP_PLAY:   play_r       <= 1'b1;
                OP_PAUSE:  play_r       <= 1'b0;
                OP_NEXT:   next_pulse_r <= 1'b1;
                OP_PREV:   prev_pulse_r <= 1'b1;
                OP_VOLUME: volume_r     <= (arg_r > VOL_MAX_8) ? VOL_MAX_5 : arg_r[4:0];
                OP_TRACK: begin
                  track_r      <= arg_r;
                  track_load_r <= 1'b1;
                end
                default: begin
                  frame_err_r <= 1'b1;
                  err_count_r <= sat_inc(err_count_r);
                end
              endcase
            end
          end
          default: state_r <= S_HDR;
        endcase
      end else if (timeout_s) begin
        state_r     <= S_HDR;
        frame_err_r <= 1'b1;
        err_count_r <= sat_inc(err_count_r);
      end
    end
  end

  assign play       = play_r;
  assign volume     = volume_r;
  assign track      = track_r;
  assign next_pulse = next_pulse_r;
  assign prev_pulse = prev_pulse_r;
  assign track_load = track_load_r;
  assign frame_err  = frame_err_r;
  assign err_count  = err_count_r;

endmodule
